// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine slice.
//   state_t  : read-engine state encoding (IDLE=0, CMD=1, RSP=2, FIN=3)
//   DEF_AW   : default bus address width
//   DEF_LW   : default word-count register width
//   ADDR_INC : byte stride between consecutive 32-bit words
package dma_pkg;

    localparam int unsigned DEF_AW   = 32;
    localparam int unsigned DEF_LW   = 16;
    localparam int unsigned ADDR_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/dma_rd_engine.sv
// DMA source-side read engine.
// Reads len_words 32-bit words starting at src_addr over an ICB-style bus,
// one read outstanding at a time, and pushes each returned word into the
// downstream DMA data FIFO. A command is only issued while the FIFO is not
// full, so the single in-flight response always has room.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : launch pulse (ignored unless idle)
//   src_addr, len_words   : byte start address / word count, sampled on start
//   busy, done, err       : status (done = 1-cycle end pulse, err = sticky bus error)
//   cmd_valid/ready/addr/read : ICB command channel (read-only)
//   rsp_valid/ready/rdata/err : ICB response channel
//   fifo_full             : downstream FIFO full flag
//   fifo_wr_req, fifo_wdata   : downstream FIFO write port
module dma_rd_engine
    import dma_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [LW-1:0] len_words,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [AW-1:0] cmd_addr,
    output logic          cmd_read,
    input  logic          rsp_valid,
    output logic          rsp_ready,
    input  logic [31:0]   rsp_rdata,
    input  logic          rsp_err,
    input  logic          fifo_full,
    output logic          fifo_wr_req,
    output logic [31:0]   fifo_wdata
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        err_d       = err_q;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        fifo_wr_req = 1'b0;
        fifo_wdata  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Word-align the start address; low two bits are dropped.
                    addr_d  = src_addr & ~AW'(3);
                    rem_d   = len_words;
                    err_d   = 1'b0;
                    state_d = (len_words == '0) ? ST_FIN : ST_CMD;
                end
            end
            ST_CMD: begin
                // Only this engine fills the FIFO, so once not-full is seen it
                // stays not-full and cmd_valid cannot drop before the handshake.
                cmd_valid = !fifo_full;
                if (!fifo_full && cmd_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    if (rsp_err) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        fifo_wr_req = 1'b1;
                        fifo_wdata  = rsp_rdata;
                        addr_d      = addr_q + AW'(ADDR_INC);
                        rem_d       = rem_q - LW'(1);
                        state_d     = (rem_q == LW'(1)) ? ST_FIN : ST_CMD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign err      = err_q;
    assign cmd_addr = addr_q;
    assign cmd_read = 1'b1;

endmodule

// File: tb/tb_dma_rd_engine.sv
// Self-checking bench for dma_rd_engine. A behavioural bus/FIFO responder
// drives random handshakes; expected addresses, word counts, data order,
// error flag and done timing are derived from the transfer parameters.
module tb_dma_rd_engine;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, err;
    logic        cmd_valid, cmd_read;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_addr;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_err = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_req;
    logic [31:0] fifo_wdata;

    dma_rd_engine #(.AW(32), .LW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .len_words(len_words), .busy(busy), .done(done), .err(err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_read(cmd_read), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .fifo_full(fifo_full),
        .fifo_wr_req(fifo_wr_req), .fifo_wdata(fifo_wdata)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0, checks = 0, viol = 0, cyc = 0;
    // responder knobs
    int unsigned rdy_pct = 100, full_pct = 0, max_wait = 0;
    int          force_wait = -1;
    bit          bp_arm = 0;
    int unsigned full_left = 0;
    // responder state
    bit          pend = 0;
    int unsigned pend_wait = 0, rsp_idx = 0, err_idx = 32'hFFFF_FFFF;
    // observations
    logic [31:0] got_addr[$], got_data[$], exp_data[$];
    int unsigned cmd_cyc[$], wr_cyc[$];
    int unsigned done_cnt = 0, busy_cnt = 0, done_cyc = 0;

    // One clock cycle: drive inputs at negedge, observe 1ns later.
    task automatic cycle(input logic st, input logic [31:0] a, input logic [15:0] n);
        logic acc;
        @(negedge clk);
        cyc++;
        start     = st;
        src_addr  = a;
        len_words = n;
        cmd_ready = ($urandom_range(99) < rdy_pct);
        fifo_full = (full_left != 0) || ($urandom_range(99) < full_pct);
        if (full_left != 0) full_left--;
        rsp_valid = pend && (pend_wait == 0);
        if (pend && pend_wait != 0) pend_wait--;
        rsp_rdata = $urandom;
        rsp_err   = rsp_valid && (rsp_idx == err_idx);
        #1;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (cmd_read !== 1'b1) viol++;
        if (fifo_full && cmd_valid !== 1'b0) viol++;
        acc = rsp_valid && (rsp_ready === 1'b1);
        if (fifo_wr_req !== (acc && !rsp_err)) viol++;
        if (fifo_wr_req === 1'b1) begin
            got_data.push_back(fifo_wdata);
            wr_cyc.push_back(cyc);
            if (bp_arm && wr_cyc.size() == 1) full_left = 5;
        end
        if (acc) begin
            if (!rsp_err) exp_data.push_back(rsp_rdata);
            pend = 0;
            rsp_idx++;
        end
        if (cmd_valid === 1'b1 && cmd_ready) begin
            if (pend) viol++;
            got_addr.push_back(cmd_addr);
            cmd_cyc.push_back(cyc);
            pend = 1;
            pend_wait = (force_wait >= 0) ? int'(force_wait) : $urandom_range(max_wait);
        end
    endtask

    task automatic run_xfer(input string name, input logic [31:0] a, input logic [15:0] n,
                            input int unsigned err_at, input int unsigned restart_off,
                            output int unsigned done_rel, output int unsigned busy_cycles);
        int unsigned st_cyc, n_cmd, n_wr, v0;
        logic        exp_err, exp_cv;
        got_addr.delete(); got_data.delete(); exp_data.delete();
        cmd_cyc.delete(); wr_cyc.delete();
        done_cnt = 0; busy_cnt = 0; rsp_idx = 0; err_idx = err_at; v0 = viol;
        exp_err = (err_at < 32'(n));
        n_cmd   = exp_err ? err_at + 1 : 32'(n);
        n_wr    = exp_err ? err_at : 32'(n);

        cycle(1'b1, a, n);
        st_cyc = cyc;
        cycle(1'b0, 32'($urandom), 16'($urandom));
        exp_cv = (n != 0) && !fifo_full;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || cmd_valid !== exp_cv) begin
            errors++;
            $display("FAIL %s first_cycle: busy=%b err=%b cmd_valid=%b, want busy=1 err=0 cmd_valid=%b",
                     name, busy, err, cmd_valid, exp_cv);
        end
        for (int unsigned k = 2; k < 3000 && done_cnt == 0; k++)
            cycle(k == restart_off, 32'($urandom), 16'($urandom));
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s timeout: no done within 3000 cycles, want done", name);
        end
        done_rel = (done_cnt != 0) ? done_cyc - st_cyc : 0;

        cycle(1'b0, 32'($urandom), 16'($urandom));
        busy_cycles = busy_cnt;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== exp_err) begin
            errors++;
            $display("FAIL %s after_done: busy=%b done=%b err=%b, want busy=0 done=0 err=%b",
                     name, busy, done, err, exp_err);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d, want 1", name, done_cnt);
        end
        checks++;
        if (got_addr.size() !== n_cmd) begin
            errors++;
            $display("FAIL %s cmd_count: got %0d, want %0d", name, got_addr.size(), n_cmd);
        end
        for (int unsigned i = 0; i < n_cmd && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== (a & ~32'd3) + 32'(4 * i)) begin
                errors++;
                $display("FAIL %s cmd_addr[%0d]: got %h, want %h", name, i, got_addr[i],
                         (a & ~32'd3) + 32'(4 * i));
            end
        end
        checks++;
        if (got_data.size() !== n_wr || exp_data.size() !== n_wr) begin
            errors++;
            $display("FAIL %s write_count: got %0d writes, %0d accepted good responses, want %0d",
                     name, got_data.size(), exp_data.size(), n_wr);
        end
        for (int unsigned i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL %s wdata[%0d]: got %h, want %h", name, i, got_data[i], exp_data[i]);
            end
        end
        checks++;
        if (viol !== v0) begin
            errors++;
            $display("FAIL %s invariants: %0d cycle violations, want 0", name, viol - v0);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_valid !== 1'b0 ||
            rsp_ready !== 1'b0 || fifo_wr_req !== 1'b0 || cmd_addr !== '0 || fifo_wdata !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b err=%b cv=%b rr=%b wr=%b addr=%h wd=%h, want all 0",
                     busy, done, err, cmd_valid, rsp_ready, fifo_wr_req, cmd_addr, fifo_wdata);
        end
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        rst_n = 1'b1;
        cycle(1'b0, '0, '0);
    endtask

    task automatic test_basic();
        int unsigned dr, bc;
        rdy_pct = 100; full_pct = 0; max_wait = 0; bp_arm = 0;
        run_xfer("basic", 32'h1000, 16'd4, 32'hFFFF_FFFF, 0, dr, bc);
        checks++;
        if (dr !== 9 || bc !== 9) begin
            errors++;
            $display("FAIL basic_timing: done at %0d busy %0d cycles, want 9 and 9", dr, bc);
        end
    endtask

    task automatic test_backpressure();
        int unsigned dr, bc;
        rdy_pct = 100; full_pct = 0; max_wait = 0; bp_arm = 1;
        run_xfer("backpressure", 32'h2000, 16'd4, 32'hFFFF_FFFF, 0, dr, bc);
        bp_arm = 0;
        checks++;
        if (cmd_cyc.size() < 2 || wr_cyc.size() < 1 || cmd_cyc[1] - wr_cyc[0] !== 6 || dr !== 14) begin
            errors++;
            $display("FAIL backpressure_stall: cmd2 gap=%0d done at %0d, want gap 6 done 14",
                     (cmd_cyc.size() >= 2 && wr_cyc.size() >= 1) ? cmd_cyc[1] - wr_cyc[0] : 0, dr);
        end
    endtask

    task automatic test_bus_error();
        int unsigned dr, bc;
        rdy_pct = 100; full_pct = 0; max_wait = 0;
        run_xfer("bus_error", 32'h3000, 16'd3, 1, 0, dr, bc);
        // next start must clear the sticky error (checked in first cycle)
        run_xfer("after_error", 32'h3100, 16'd2, 32'hFFFF_FFFF, 0, dr, bc);
    endtask

    task automatic test_zero_and_wrap();
        int unsigned dr, bc;
        rdy_pct = 100; full_pct = 0; max_wait = 0;
        run_xfer("zero_len", 32'h4000, 16'd0, 32'hFFFF_FFFF, 0, dr, bc);
        checks++;
        if (dr !== 1 || bc !== 1) begin
            errors++;
            $display("FAIL zero_len_timing: done at %0d busy %0d cycles, want 1 and 1", dr, bc);
        end
        run_xfer("wrap", 32'hFFFF_FFFC, 16'd2, 32'hFFFF_FFFF, 0, dr, bc);
        run_xfer("unaligned", 32'h0000_5003, 16'd3, 32'hFFFF_FFFF, 0, dr, bc);
    endtask

    task automatic test_restart_ignored();
        int unsigned dr, bc;
        rdy_pct = 100; full_pct = 0; max_wait = 1;
        run_xfer("restart_busy", 32'h6000, 16'd5, 32'hFFFF_FFFF, 3, dr, bc);
    endtask

    task automatic test_reset_mid();
        int unsigned n0;
        rdy_pct = 100; full_pct = 0; force_wait = 4;
        got_data.delete(); done_cnt = 0; rsp_idx = 0; err_idx = 32'hFFFF_FFFF;
        cycle(1'b1, 32'h7000, 16'd3);
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        checks++;
        if (rsp_ready !== 1'b1 || pend !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: rsp_ready=%b pending=%b, want 1 1", rsp_ready, pend);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_valid !== 1'b0 ||
            rsp_ready !== 1'b0 || fifo_wr_req !== 1'b0 || cmd_addr !== '0 || fifo_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b done=%b err=%b cv=%b rr=%b wr=%b addr=%h, want all 0",
                     busy, done, err, cmd_valid, rsp_ready, fifo_wr_req, cmd_addr);
        end
        n0 = rsp_idx;
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0);
        checks++;
        if (got_data.size() !== 0 || done_cnt !== 0 || rsp_idx !== n0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_late_rsp: writes=%0d done=%0d accepted=%0d busy=%b, want 0 0 0 0",
                     got_data.size(), done_cnt, rsp_idx - n0, busy);
        end
        pend = 0; force_wait = -1;
        cycle(1'b0, '0, '0);
    endtask

    task automatic test_random();
        int unsigned dr, bc, n, ea;
        rdy_pct = 60; full_pct = 30; max_wait = 3;
        for (int t = 0; t < 10; t++) begin
            n  = $urandom_range(10, 1);
            ea = ($urandom_range(3) == 0) ? $urandom_range(n - 1, 0) : 32'hFFFF_FFFF;
            run_xfer($sformatf("random%0d", t), $urandom, 16'(n), ea, 0, dr, bc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bus_error();
        test_zero_and_wrap();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
